// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Bundles the operand/strobe/result signals between the ALU sequencer and the ALU.
//   master modport (sequencer): drives alu_bus_o, alu_in1_en, alu_in2_en,
//                               alu_out_en, alu_out_reg_en, alu_op;
//                               receives alu_result_i
//   slave modport (ALU):        the mirror image of master
interface alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] alu_bus_o;
    logic             alu_in1_en;
    logic             alu_in2_en;
    logic             alu_out_en;
    logic             alu_out_reg_en;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result_i;

    modport master (
        output alu_bus_o,
        output alu_in1_en,
        output alu_in2_en,
        output alu_out_en,
        output alu_out_reg_en,
        output alu_op,
        input  alu_result_i
    );

    modport slave (
        input  alu_bus_o,
        input  alu_in1_en,
        input  alu_in2_en,
        input  alu_out_en,
        input  alu_out_reg_en,
        input  alu_op,
        output alu_result_i
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Initiator side of the ALU: holds an NREGS x WIDTH register file and runs one
// ALU operation per start command (load operand 1, load operand 2 unless NOT,
// execute, write the result back to the destination register).
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, op, rd,    command strobe plus opcode and register addresses,
//   rs1, rs2          accepted only in IDLE
//   busy, done        busy outside IDLE; done pulses for one cycle in WB
//   wr_en, wr_addr,   host write port, honoured only in IDLE
//   wr_data
//   rd_addr, rd_data  host combinational read port
//   alu               operand bus, strobes, opcode and result to/from the ALU
module alu_sequencer #(
    parameter int  WIDTH = 16,
    parameter int  NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [AW-1:0]         rd,
    input  logic [AW-1:0]         rs1,
    input  logic [AW-1:0]         rs2,
    output logic                  busy,
    output logic                  done,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    alu_sequencer_if.master       alu
);

    localparam logic [2:0] OP_NOT = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        LOAD2,
        EXEC,
        WB
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [WIDTH-1:0] regs [NREGS];

    // State register and command latch. The command is captured only when
    // a start is accepted in IDLE, so a start while busy is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                op_q  <= op;
                rd_q  <= rd;
                rs1_q <= rs1;
                rs2_q <= rs2;
            end
        end
    end

    // Register file. Host writes and ALU write-back happen in different
    // states, so they can never collide. Sources are read during LOAD1/LOAD2,
    // which is why rd may alias rs1/rs2 and why a host write on the start edge
    // is seen by the operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == IDLE && wr_en) begin
            regs[wr_addr] <= wr_data;
        end else if (state == WB) begin
            regs[rd_q] <= alu.alu_result_i;
        end
    end

    // Next-state and Moore output decode. Only one strobe is ever active
    // because each belongs to exactly one state.
    always_comb begin
        state_next         = state;
        busy               = 1'b1;
        done               = 1'b0;
        alu.alu_bus_o      = '0;
        alu.alu_in1_en     = 1'b0;
        alu.alu_in2_en     = 1'b0;
        alu.alu_out_en     = 1'b0;
        alu.alu_out_reg_en = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD1;
                end
            end
            LOAD1: begin
                alu.alu_bus_o  = regs[rs1_q];
                alu.alu_in1_en = 1'b1;
                // NOT has a single operand, so operand 2 is skipped.
                state_next = (op_q == OP_NOT) ? EXEC : LOAD2;
            end
            LOAD2: begin
                alu.alu_bus_o  = regs[rs2_q];
                alu.alu_in2_en = 1'b1;
                state_next     = EXEC;
            end
            EXEC: begin
                alu.alu_out_en     = 1'b1;
                alu.alu_out_reg_en = 1'b1;
                state_next         = WB;
            end
            WB: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The opcode register is held after an operation so the ALU keeps seeing
    // the last opcode while idle.
    assign alu.alu_op = op_q;
    assign rd_data    = regs[rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Self-checking bench for alu_sequencer: a behavioural ALU stub on the slave
// side of the interface, a register-file reference model, and a monitor that
// pops expected results whenever the sequencer presents them.
module tb_alu_sequencer;

    localparam logic [2:0] OP_NOT = 3'd2;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  rd;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] result;
        int          start_cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;

    logic [1:0]  stim_addr;
    logic [1:0]  mon_addr;
    logic        mon_busy;
    logic [15:0] mon_exp;

    logic [15:0] alu_a1;
    logic [15:0] alu_a2;
    logic [15:0] alu_res;

    logic [15:0] ref_regs [4];
    exp_t        exp_q [$];
    int          cycle_cnt;
    int          err_count;
    int          check_count;

    alu_sequencer_if #(.WIDTH(16)) alu_bus ();

    alu_sequencer #(.WIDTH(16), .NREGS(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .alu     (alu_bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // The monitor borrows the read port while a write-back check is pending.
    assign rd_addr = mon_busy ? mon_addr : stim_addr;

    // What the ALU computes for each opcode; the reserved opcode returns a
    // recognisable constant so its write-back can be checked.
    function automatic logic [15:0] alu_fn(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~a;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return 16'hBEEF;
        endcase
    endfunction

    // Behavioural ALU: operands captured on their load strobes, result
    // registered on the output-register enable.
    always @(posedge clk) begin
        if (reset) begin
            alu_a1  <= '0;
            alu_a2  <= '0;
            alu_res <= '0;
        end else begin
            if (alu_bus.alu_in1_en) alu_a1 <= alu_bus.alu_bus_o;
            if (alu_bus.alu_in2_en) alu_a2 <= alu_bus.alu_bus_o;
            if (alu_bus.alu_out_reg_en) alu_res <= alu_fn(alu_bus.alu_op, alu_a1, alu_a2);
        end
    end
    assign alu_bus.alu_result_i = alu_res;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: checks operand bus contents, strobe exclusivity, done latency
    // and the written-back value against the head of the scoreboard queue.
    initial begin
        mon_busy = 1'b0;
        mon_addr = '0;
        mon_exp  = '0;
        forever begin
            @(negedge clk);
            if (mon_busy) begin
                checkOutput("wb_value", rd_data, mon_exp);
                mon_busy = 1'b0;
            end
            if (alu_bus.alu_in1_en || alu_bus.alu_in2_en || alu_bus.alu_out_en || done) begin
                checkOutput("strobe_onehot",
                            $countones({alu_bus.alu_in1_en, alu_bus.alu_in2_en, alu_bus.alu_out_en, done}), 1);
                checkOutput("out_reg_en_pair", alu_bus.alu_out_reg_en, alu_bus.alu_out_en);
            end
            if (alu_bus.alu_in1_en) begin
                checkOutput("in1_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    checkOutput("in1_bus", alu_bus.alu_bus_o, exp_q[0].op1);
                    checkOutput("in1_op", alu_bus.alu_op, exp_q[0].op);
                end
            end
            if (alu_bus.alu_in2_en) begin
                checkOutput("in2_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    checkOutput("in2_on_not", exp_q[0].op == OP_NOT, 0);
                    checkOutput("in2_bus", alu_bus.alu_bus_o, exp_q[0].op2);
                end
            end
            if (done) begin
                checkOutput("done_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    checkOutput("done_latency", cycle_cnt - exp_q[0].start_cnt,
                                (exp_q[0].op == OP_NOT) ? 2 : 3);
                    mon_exp  = exp_q[0].result;
                    mon_addr = exp_q[0].rd;
                    mon_busy = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic hostWrite(input logic [1:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        ref_regs[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic readReg(input string name, input logic [1:0] a, input logic [15:0] expected);
        stim_addr = a;
        #1;
        checkOutput(name, rd_data, expected);
    endtask

    // Issues one command, optionally with a same-edge host write, pushes the
    // expected outcome and waits (bounded) for the sequencer to go idle.
    task automatic applyStimulus(input logic [2:0] f, input logic [1:0] d, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic do_wr, input logic [1:0] wa,
                                 input logic [15:0] wd);
        exp_t e;
        int   busy_cnt;
        start = 1'b1;
        op    = f;
        rd    = d;
        rs1   = s1;
        rs2   = s2;
        wr_en   = do_wr;
        wr_addr = wa;
        wr_data = wd;
        if (do_wr) ref_regs[wa] = wd;
        e.op        = f;
        e.rd        = d;
        e.op1       = ref_regs[s1];
        e.op2       = ref_regs[s2];
        e.result    = alu_fn(f, ref_regs[s1], ref_regs[s2]);
        e.start_cnt = cycle_cnt + 1;
        exp_q.push_back(e);
        ref_regs[d] = e.result;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            busy_cnt++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", busy_cnt, (f == OP_NOT) ? 3 : 4);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_strobes"},
                    {alu_bus.alu_in1_en, alu_bus.alu_in2_en, alu_bus.alu_out_en, alu_bus.alu_out_reg_en}, 0);
        checkOutput({tag, "_bus"}, alu_bus.alu_bus_o, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busy_cnt;
        err_count   = 0;
        check_count = 0;
        cycle_cnt   = 0;
        reset     = 1'b1;
        start     = 1'b0;
        op        = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        stim_addr = '0;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkIdleOutputs("reset");
        checkOutput("reset_alu_op", alu_bus.alu_op, 0);
        for (int i = 0; i < 4; i++) readReg("reset_reg", 2'(i), 16'h0000);

        // ADD
        hostWrite(2'd1, 16'h0005);
        hostWrite(2'd2, 16'h0007);
        applyStimulus(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0);
        repeat (2) @(negedge clk);
        readReg("add_r3", 2'd3, 16'h000C);
        checkOutput("alu_op_held", alu_bus.alu_op, 0);

        // SUB wrap
        hostWrite(2'd1, 16'h0003);
        hostWrite(2'd2, 16'h0005);
        applyStimulus(3'd1, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0);
        repeat (2) @(negedge clk);
        readReg("sub_r3", 2'd3, 16'hFFFE);

        // NOT in place
        hostWrite(2'd0, 16'h00F0);
        applyStimulus(3'd2, 2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 16'h0);
        repeat (2) @(negedge clk);
        readReg("not_r0", 2'd0, 16'hFF0F);

        // Start and host write while busy are both ignored.
        hostWrite(2'd2, 16'h5A5A);
        start = 1'b1; op = 3'd0; rd = 2'd1; rs1 = 2'd1; rs2 = 2'd2;
        begin
            exp_t e;
            e.op = 3'd0; e.rd = 2'd1; e.op1 = ref_regs[1]; e.op2 = ref_regs[2];
            e.result = ref_regs[1] + ref_regs[2];
            e.start_cnt = cycle_cnt + 1;
            exp_q.push_back(e);
            ref_regs[1] = e.result;
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd5; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd0;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            busy_cnt++;
            @(negedge clk);
        end
        checkOutput("busy_tail_cycles", busy_cnt, 2);
        repeat (4) @(negedge clk);
        readReg("ignored_r2", 2'd2, 16'h5A5A);
        readReg("busy_add_r1", 2'd1, ref_regs[1]);

        // Reset during EXEC aborts with no write-back.
        start = 1'b1; op = 3'd4; rd = 2'd3; rs1 = 2'd1; rs2 = 2'd2;
        begin
            exp_t e;
            e.op = 3'd4; e.rd = 2'd3; e.op1 = ref_regs[1]; e.op2 = ref_regs[2];
            e.result = ref_regs[1] | ref_regs[2];
            e.start_cnt = cycle_cnt + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("exec_out_en", alu_bus.alu_out_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        checkIdleOutputs("abort");
        checkOutput("abort_alu_op", alu_bus.alu_op, 0);
        for (int i = 0; i < 4; i++) readReg("abort_reg", 2'(i), 16'h0000);
        repeat (4) @(negedge clk);
        readReg("abort_no_wb", 2'd3, 16'h0000);

        // Same-edge host write and start: the fresh value is the operand.
        hostWrite(2'd2, 16'h00FF);
        applyStimulus(3'd3, 2'd3, 2'd1, 2'd2, 1'b1, 2'd1, 16'h1234);
        repeat (2) @(negedge clk);
        readReg("and_r3", 2'd3, 16'h0034);

        // Randomised operations, including aliasing and the reserved opcode.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) hostWrite(2'($urandom_range(0, 3)), 16'($urandom));
            applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          16'($urandom));
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) readReg("final_reg", 2'(i), ref_regs[i]);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
